// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath width, register address width,
// architecturally special register numbers and common typedefs.
package mips_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;

    // Register number $zero: always reads 0; writes to it are discarded.
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
    // Register number $ra: link register written by jal.
    localparam logic [REG_ADDR_WIDTH-1:0] REG_RA   = 5'd31;

    typedef logic [DATA_WIDTH-1:0]     word_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_2r1w_read_port.sv
// regfile_read_port: one combinational read port of the register file.
// Selects a register from the flattened array, forces register 0 to read
// as zero and, when BYPASS is set, forwards the in-flight write data to
// the output if it targets the same register.
module regfile_read_port
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH,
    parameter bit BYPASS     = 1'b0
) (
    input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]                      rd_addr,
    input  logic                                       byp_valid,
    input  logic [ADDR_WIDTH-1:0]                      byp_addr,
    input  logic [DATA_WIDTH-1:0]                      byp_data,
    output logic [DATA_WIDTH-1:0]                      rd_data
);

    // Register 0 wins over everything, then the write-through forward, then the array.
    always_comb begin
        rd_data = regs[rd_addr];
        if (rd_addr == ADDR_WIDTH'(REG_ZERO)) begin
            rd_data = '0;
        end else if (BYPASS && byp_valid && (byp_addr == rd_addr)) begin
            rd_data = byp_data;
        end
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: MIPS multicycle register file with two read ports, one
// write port, a separate HI/LO pair and a read-only debug port.
// Reads are combinational; writes occur on the rising clock edge.
// Reset (rst) is asynchronous and active low.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards write data to the
// operand read ports and hi_in/lo_in to hi_out/lo_out in the write cycle.
// The debug port is never forwarded.
module reg_file_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  hilo_wr_en,
    input  logic [DATA_WIDTH-1:0] hi_in,
    input  logic [DATA_WIDTH-1:0] lo_in,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    // Registers 1..DEPTH-1 only; register 0 is a constant and has no storage.
    logic [DEPTH-1:1][DATA_WIDTH-1:0] mem;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_flat;
    logic [DATA_WIDTH-1:0]            hi_q;
    logic [DATA_WIDTH-1:0]            lo_q;
    logic                             gp_write;
    logic                             byp_valid;

    assign regs_flat = {mem, {DATA_WIDTH{1'b0}}};

    // A write is effective only for a nonzero destination register.
    assign gp_write  = wr_en && (wr_addr != ADDR_WIDTH'(REG_ZERO));

    // Forwarding is suppressed while reset is held so every output reads 0.
    assign byp_valid = gp_write && rst;

    // General register array: cleared by reset, written on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '0;
        end else if (gp_write) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // HI/LO pair: written together, independently of the general write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_wr_en) begin
            hi_q <= hi_in;
            lo_q <= lo_in;
        end
    end

    // HI/LO outputs: stored value, or the incoming value when forwarding is built in.
    always_comb begin
        hi_out = hi_q;
        lo_out = lo_q;
        if (BYPASS_EN && hilo_wr_en && rst) begin
            hi_out = hi_in;
            lo_out = lo_in;
        end
    end

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS_EN)
    ) u_port1 (
        .regs      (regs_flat),
        .rd_addr   (rd_addr1),
        .byp_valid (byp_valid),
        .byp_addr  (wr_addr),
        .byp_data  (wr_data),
        .rd_data   (rd_data1)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS_EN)
    ) u_port2 (
        .regs      (regs_flat),
        .rd_addr   (rd_addr2),
        .byp_valid (byp_valid),
        .byp_addr  (wr_addr),
        .byp_data  (wr_data),
        .rd_data   (rd_data2)
    );

    // The debug port always shows the stored array contents.
    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (1'b0)
    ) u_dbg (
        .regs      (regs_flat),
        .rd_addr   (dbg_addr),
        .byp_valid (1'b0),
        .byp_addr  ({ADDR_WIDTH{1'b0}}),
        .byp_data  ({DATA_WIDTH{1'b0}}),
        .rd_data   (dbg_data)
    );

    // An unknown write address with the write enabled would corrupt an arbitrary register.
    assert property (@(posedge clk) disable iff (!rst) wr_en |-> !$isunknown(wr_addr))
        else $error("reg_file_2r1w: wr_addr unknown while wr_en is asserted");

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: reset, write/read, register 0,
// same-cycle read/write (both builds), HI/LO and a full address sweep.
module tb_reg_file_2r1w;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        hilo_wr_en;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    reg_file_2r1w dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .hilo_wr_en (hilo_wr_en),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one write cycle, let it land on the rising edge, then drop the enables.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic hwe, input logic [31:0] hi, input logic [31:0] lo);
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        hilo_wr_en = hwe;
        hi_in      = hi;
        lo_in      = lo;
        @(posedge clk);
        #1;
        wr_en      = 1'b0;
        hilo_wr_en = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_val;
        logic [31:0] pre_edge_exp;

        rst        = 1'b0;
        rd_addr1   = 5'd0;
        rd_addr2   = 5'd0;
        wr_en      = 1'b0;
        wr_addr    = 5'd0;
        wr_data    = 32'h0;
        hilo_wr_en = 1'b0;
        hi_in      = 32'h0;
        lo_in      = 32'h0;
        dbg_addr   = 5'd0;

        // Reset state
        #2;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd31;
        dbg_addr = 5'd7;
        #1;
        checkOutput("reset_rd1", rd_data1, 32'h0);
        checkOutput("reset_rd2", rd_data2, 32'h0);
        checkOutput("reset_dbg", dbg_data, 32'h0);
        checkOutput("reset_hi", hi_out, 32'h0);
        checkOutput("reset_lo", lo_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Preload r5 and HI/LO, then assert reset mid-cycle
        applyStimulus(1'b1, 5'd5, 32'h0000_1234, 1'b1, 32'h55, 32'h66);
        rd_addr1 = 5'd5;
        #1;
        checkOutput("preload_r5", rd_data1, 32'h0000_1234);
        checkOutput("preload_hi", hi_out, 32'h55);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("async_rst_r5", rd_data1, 32'h0);
        checkOutput("async_rst_hi", hi_out, 32'h0);
        checkOutput("async_rst_lo", lo_out, 32'h0);

        // A write held across a clock edge during reset must be dropped
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'h0000_9999;
        @(posedge clk);
        #1;
        checkOutput("rst_write_out", rd_data1, 32'h0);
        @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b1;
        #1;
        checkOutput("rst_write_dropped", rd_data1, 32'h0);

        // Write/read on both ports
        applyStimulus(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
        rd_addr1 = 5'd8;
        rd_addr2 = 5'd8;
        #1;
        checkOutput("wr8_rd1", rd_data1, 32'hDEAD_BEEF);
        checkOutput("wr8_rd2", rd_data2, 32'hDEAD_BEEF);

        // wr_en low must leave the register untouched
        applyStimulus(1'b0, 5'd8, 32'h0000_0077, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("no_we_r8", rd_data1, 32'hDEAD_BEEF);

        // Register 0 ignores writes
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0);
        rd_addr1 = 5'd0;
        dbg_addr = 5'd0;
        #1;
        checkOutput("r0_rd1", rd_data1, 32'h0);
        checkOutput("r0_dbg", dbg_data, 32'h0);

        // Same-cycle read/write of r3
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rd_addr1 = 5'd3;
        rd_addr2 = 5'd3;
        dbg_addr = 5'd3;
        wr_en    = 1'b1;
        wr_addr  = 5'd3;
        wr_data  = 32'h22;
        #1;
`ifdef REGFILE_BYPASS_EN
        pre_edge_exp = 32'h22;
`else
        pre_edge_exp = 32'h11;
`endif
        checkOutput("same_cyc_pre_rd1", rd_data1, pre_edge_exp);
        checkOutput("same_cyc_pre_rd2", rd_data2, pre_edge_exp);
        checkOutput("same_cyc_pre_dbg", dbg_data, 32'h11);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        checkOutput("same_cyc_post_rd1", rd_data1, 32'h22);
        checkOutput("same_cyc_post_dbg", dbg_data, 32'h22);

        // HI/LO and general write in the same cycle
        applyStimulus(1'b1, 5'd31, 32'hC, 1'b1, 32'hA, 32'hB);
        dbg_addr = 5'd31;
        #1;
        checkOutput("hilo_hi", hi_out, 32'hA);
        checkOutput("hilo_lo", lo_out, 32'hB);
        checkOutput("hilo_r31", dbg_data, 32'hC);

        // Sweep: fill r1..r31, then read every address on all three ports
        for (int a = 1; a < 32; a++) begin
            applyStimulus(1'b1, 5'(a), 32'h5A5A_0000 ^ 32'(a), 1'b0, 32'h0, 32'h0);
        end
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            dbg_addr = 5'(a);
            #1;
            exp_val = (a == 0) ? 32'h0 : (32'h5A5A_0000 ^ 32'(a));
            checkOutput($sformatf("sweep_rd1_%0d", a), rd_data1, exp_val);
            checkOutput($sformatf("sweep_dbg_%0d", a), dbg_data, exp_val);
            exp_val = (a == 31) ? 32'h0 : (32'h5A5A_0000 ^ 32'(31 - a));
            checkOutput($sformatf("sweep_rd2_%0d", 31 - a), rd_data2, exp_val);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
